// File: rtl/ring_mon_pkg.sv
// Shared types and helpers for the ring phase monitor.
// Helpers take a zero-extended MAX_W vector so one function serves any ring width.
package ring_mon_pkg;

    localparam int unsigned MAX_W        = 32;
    localparam int unsigned DEF_LOCK_CNT = 2;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        LOCKED  = 2'd1,
        FAULT   = 2'd2
    } state_t;

    function automatic logic is_onehot(input logic [MAX_W-1:0] v);
        return (v != '0) && ((v & (v - MAX_W'(1))) == '0);
    endfunction

    // Rotate right by one within the low w bits; bit 0 wraps to bit w-1.
    function automatic logic [MAX_W-1:0] rotr1(input logic [MAX_W-1:0] v,
                                               input int unsigned w);
        return (v >> 1) | (MAX_W'(v[0]) << (w - 1));
    endfunction

endpackage

// File: rtl/ring_onehot_dec.sv
// One-hot to index decoder: MSB maps to index 0, LSB to WIDTH-1.
module ring_onehot_dec
    import ring_mon_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0]         vec,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     vld
);

    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (vec[i]) idx = ($clog2(WIDTH))'(WIDTH - 1 - i);
        end
        vld = is_onehot(MAX_W'(vec));
    end

endmodule

// File: rtl/ring_phase_monitor.sv
// Phase decode, transition checking, lock and revolution tracking for a one-hot ring.
// Optional error capture ports: define RING_PHASE_MON_CAPTURE_EN.
module ring_phase_monitor
    import ring_mon_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned REV_W    = 8,
    parameter int unsigned LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     step_en,
    input  logic                     clr_err,
    output logic [$clog2(WIDTH)-1:0] phase,
    output logic                     phase_vld,
    output logic                     locked,
    output logic [REV_W-1:0]         rev_cnt,
    output logic                     rev_pulse,
    output logic                     err_illegal,
    output logic                     err_skip,
`ifdef RING_PHASE_MON_CAPTURE_EN
    output logic [WIDTH-1:0]         err_pattern,
    output logic [$clog2(WIDTH)-1:0] err_phase,
`endif
    output logic                     err_sticky
);

    state_t                     state, state_nxt;
    logic [WIDTH-1:0]           prev, prev_nxt, expected;
    logic                       prev_vld, prev_vld_nxt;
    logic [3:0]                 cnt, cnt_nxt, cnt_inc;
    logic [REV_W-1:0]           rev_nxt;
    logic                       pulse_nxt, ill_nxt, skip_nxt, sticky_nxt, match;
    logic [$clog2(WIDTH)-1:0]   in_idx;
    logic                       in_vld;

    ring_onehot_dec #(.WIDTH(WIDTH)) u_in_dec (
        .vec (ring_in),
        .idx (in_idx),
        .vld (in_vld)
    );

    always_comb begin
        expected = step_en ? WIDTH'(rotr1(MAX_W'(prev), WIDTH)) : prev;
        match    = in_vld && (ring_in == expected);
        cnt_inc  = cnt + 4'd1;
    end

    always_comb begin
        state_nxt    = state;
        prev_nxt     = prev;
        prev_vld_nxt = prev_vld;
        cnt_nxt      = cnt;
        rev_nxt      = rev_cnt;
        pulse_nxt    = 1'b0;
        ill_nxt      = 1'b0;
        skip_nxt     = 1'b0;

        if (in_vld) begin
            prev_nxt     = ring_in;
            prev_vld_nxt = 1'b1;
        end

        case (state)
            ACQUIRE: begin
                if (!in_vld) begin
                    cnt_nxt      = '0;
                    prev_vld_nxt = 1'b0;
                end else if (prev_vld) begin
                    if (!match) begin
                        cnt_nxt = '0;
                    end else if (step_en) begin
                        if (cnt_inc == 4'(LOCK_CNT)) begin
                            state_nxt = LOCKED;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                end
            end
            LOCKED: begin
                if (!in_vld) begin
                    ill_nxt   = 1'b1;
                    state_nxt = FAULT;
                end else if (!match) begin
                    skip_nxt  = 1'b1;
                    state_nxt = FAULT;
                end else if (step_en && prev[0]) begin
                    rev_nxt   = rev_cnt + 1'b1;
                    pulse_nxt = 1'b1;
                end
            end
            FAULT: begin
                state_nxt    = ACQUIRE;
                cnt_nxt      = '0;
                prev_vld_nxt = 1'b0;
            end
            default: begin
                state_nxt    = ACQUIRE;
                cnt_nxt      = '0;
                prev_vld_nxt = 1'b0;
            end
        endcase

        // A new error outranks a simultaneous clear.
        sticky_nxt = ill_nxt | skip_nxt | (err_sticky & ~clr_err);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ACQUIRE;
            prev        <= '0;
            prev_vld    <= 1'b0;
            cnt         <= '0;
            phase       <= '0;
            phase_vld   <= 1'b0;
            locked      <= 1'b0;
            rev_cnt     <= '0;
            rev_pulse   <= 1'b0;
            err_illegal <= 1'b0;
            err_skip    <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            state       <= state_nxt;
            prev        <= prev_nxt;
            prev_vld    <= prev_vld_nxt;
            cnt         <= cnt_nxt;
            if (in_vld) phase <= in_idx;
            phase_vld   <= in_vld;
            locked      <= (state_nxt == LOCKED);
            rev_cnt     <= rev_nxt;
            rev_pulse   <= pulse_nxt;
            err_illegal <= ill_nxt;
            err_skip    <= skip_nxt;
            err_sticky  <= sticky_nxt;
        end
    end

`ifdef RING_PHASE_MON_CAPTURE_EN
    logic [$clog2(WIDTH)-1:0] exp_idx;
    logic                     exp_vld;

    ring_onehot_dec #(.WIDTH(WIDTH)) u_exp_dec (
        .vec (expected),
        .idx (exp_idx),
        .vld (exp_vld)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_pattern <= '0;
            err_phase   <= '0;
        end else if (ill_nxt || skip_nxt) begin
            err_pattern <= ring_in;
            err_phase   <= exp_vld ? exp_idx : '0;
        end
    end
`endif

endmodule
